// File: rtl/process_features_mul_pipe.sv
// Pipelined multiplier with per-operand signedness, valid/ready backpressure and a tag sideband.
// Define MUL_PIPE_SATURATE_EN to clamp the product instead of truncating it to dout_WIDTH.
module process_features_mul_pipe #(
  parameter int ID          = 1,
  parameter int NUM_STAGE   = 3,
  parameter int din0_WIDTH  = 8,
  parameter int din1_WIDTH  = 10,
  parameter int dout_WIDTH  = 17,
  parameter int din0_SIGNED = 0,
  parameter int din1_SIGNED = 0,
  parameter int TAG_WIDTH   = 4
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [dout_WIDTH-1:0] dout,
  output logic [TAG_WIDTH-1:0]  out_tag
);

  localparam int PW = din0_WIDTH + din1_WIDTH + 1;
  localparam int ID_UNUSED = ID;

  logic signed [PW-1:0]  a_wide;
  logic signed [PW-1:0]  b_wide;
  logic signed [PW-1:0]  prod;
  logic                  ce;
  logic [NUM_STAGE-1:0]  vld_reg;
  logic [PW-1:0]         p_reg   [NUM_STAGE];
  logic [TAG_WIDTH-1:0]  tag_reg [NUM_STAGE];
  logic [PW-1:0]         p_last;
  logic                  p_last_unused;

  // Operands are widened to the full product width, so the low PW bits of the
  // PW x PW multiply are the exact product.
  generate
    if (din0_SIGNED != 0) begin : g_a_signed
      assign a_wide = PW'($signed(din0));
    end else begin : g_a_unsigned
      assign a_wide = $signed(PW'({1'b0, din0}));
    end
    if (din1_SIGNED != 0) begin : g_b_signed
      assign b_wide = PW'($signed(din1));
    end else begin : g_b_unsigned
      assign b_wide = $signed(PW'({1'b0, din1}));
    end
  endgenerate

  assign prod     = a_wide * b_wide;
  assign ce       = !(vld_reg[NUM_STAGE-1] && !out_ready);
  assign in_ready = ce;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      vld_reg <= '0;
      for (int i = 0; i < NUM_STAGE; i++) begin
        p_reg[i]   <= '0;
        tag_reg[i] <= '0;
      end
    end else if (ce) begin
      vld_reg[0] <= in_valid;
      p_reg[0]   <= prod;
      tag_reg[0] <= in_tag;
      for (int i = 1; i < NUM_STAGE; i++) begin
        vld_reg[i] <= vld_reg[i-1];
        p_reg[i]   <= p_reg[i-1];
        tag_reg[i] <= tag_reg[i-1];
      end
    end
  end

  assign p_last        = p_reg[NUM_STAGE-1];
  assign p_last_unused = ^p_last;
  assign out_valid     = vld_reg[NUM_STAGE-1];
  assign out_tag       = tag_reg[NUM_STAGE-1];

  // Narrowing of the final-stage product onto dout.
  generate
    if (dout_WIDTH >= PW) begin : g_full
      assign dout = p_last[dout_WIDTH-1:0];
    end else begin : g_narrow
`ifdef MUL_PIPE_SATURATE_EN
      if ((din0_SIGNED != 0) || (din1_SIGNED != 0)) begin : g_sat_signed
        logic [dout_WIDTH-1:0] sat_max;
        logic [dout_WIDTH-1:0] sat_min;
        logic                  ovf;
        assign sat_max = {1'b0, {(dout_WIDTH-1){1'b1}}};
        assign sat_min = {1'b1, {(dout_WIDTH-1){1'b0}}};
        // Fits only when every bit above the result sign bit matches it.
        assign ovf  = (|p_last[PW-1:dout_WIDTH-1]) & ~(&p_last[PW-1:dout_WIDTH-1]);
        assign dout = ovf ? (p_last[PW-1] ? sat_min : sat_max) : p_last[dout_WIDTH-1:0];
      end else begin : g_sat_unsigned
        assign dout = (|p_last[PW-1:dout_WIDTH]) ? {dout_WIDTH{1'b1}}
                                                 : p_last[dout_WIDTH-1:0];
      end
`else
      assign dout = p_last[dout_WIDTH-1:0];
`endif
    end
  endgenerate

endmodule

// File: tb/tb_process_features_mul_pipe.sv
// Bench for process_features_mul_pipe: unsigned, signed and mixed instances share one stimulus,
// checked against an arithmetic reference model and a FIFO scoreboard.
module tb_process_features_mul_pipe;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [7:0]  din0 = '0;
  logic [9:0]  din1 = '0;
  logic [3:0]  in_tag = '0;

  logic        in_ready_u, in_ready_s, in_ready_m;
  logic        out_valid_u, out_valid_s, out_valid_m;
  logic [16:0] dout_u, dout_s, dout_m;
  logic [3:0]  out_tag_u, out_tag_s, out_tag_m;

  always #5 ap_clk = ~ap_clk;

  process_features_mul_pipe dut_u (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(in_valid), .in_ready(in_ready_u),
    .din0(din0), .din1(din1), .in_tag(in_tag), .out_valid(out_valid_u),
    .out_ready(out_ready), .dout(dout_u), .out_tag(out_tag_u));

  process_features_mul_pipe #(.din0_SIGNED(1), .din1_SIGNED(1)) dut_s (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
    .din0(din0), .din1(din1), .in_tag(in_tag), .out_valid(out_valid_s),
    .out_ready(out_ready), .dout(dout_s), .out_tag(out_tag_s));

  process_features_mul_pipe #(.din0_SIGNED(0), .din1_SIGNED(1)) dut_m (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(in_valid), .in_ready(in_ready_m),
    .din0(din0), .din1(din1), .in_tag(in_tag), .out_valid(out_valid_m),
    .out_ready(out_ready), .dout(dout_m), .out_tag(out_tag_m));

  typedef struct {
    logic [7:0] a;
    logic [9:0] b;
    logic [3:0] t;
  } beat_t;

  beat_t       scb[$];
  int          checks = 0;
  int          passes = 0;
  int          cons_cnt = 0;
  bit          held = 1'b0;
  logic [16:0] held_dout;
  logic [3:0]  held_tag;
  bit          last_acc;

`ifdef MUL_PIPE_SATURATE_EN
  localparam logic [16:0] EXP_T1 = 17'h1FFFF;
  localparam logic [16:0] EXP_T2 = 17'h0FFFF;
`else
  localparam logic [16:0] EXP_T1 = 17'h1FB01;
  localparam logic [16:0] EXP_T2 = 17'h10000;
`endif

  // Reference: exact integer product, then truncation or clamping to 17 bits.
  function automatic logic [16:0] model(logic [7:0] a, logic [9:0] b, bit sa, bit sb);
    longint x;
    longint y;
    longint p;
    logic [63:0] q;
    x = longint'(a);
    y = longint'(b);
    if (sa && a[7]) x = x - 256;
    if (sb && b[9]) y = y - 1024;
    p = x * y;
`ifdef MUL_PIPE_SATURATE_EN
    if (sa || sb) begin
      if (p > 65535) p = 65535;
      if (p < -65536) p = -65536;
    end else begin
      if (p > 131071) p = 131071;
    end
`endif
    q = p;
    return q[16:0];
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // One clock: sample outputs at the falling edge, update the scoreboard, return just after the rising edge.
  task automatic step();
    beat_t e;
    @(negedge ap_clk);
    if (held) begin
      check("hold_valid", 32'(out_valid_u), 32'd1);
      check("hold_dout", 32'(dout_u), 32'(held_dout));
      check("hold_tag", 32'(out_tag_u), 32'(held_tag));
    end
    if (out_valid_u && !out_ready) begin
      check("stall_in_ready_u", 32'(in_ready_u), 32'd0);
      check("stall_in_ready_s", 32'(in_ready_s), 32'd0);
      check("stall_in_ready_m", 32'(in_ready_m), 32'd0);
    end
    held      = out_valid_u && !out_ready;
    held_dout = dout_u;
    held_tag  = out_tag_u;
    if (out_valid_u && out_ready) begin
      if (scb.size() == 0) begin
        check("spurious_out", 32'(out_valid_u), 32'd0);
      end else begin
        e = scb.pop_front();
        check("dout_u", 32'(dout_u), 32'(model(e.a, e.b, 1'b0, 1'b0)));
        check("dout_s", 32'(dout_s), 32'(model(e.a, e.b, 1'b1, 1'b1)));
        check("dout_m", 32'(dout_m), 32'(model(e.a, e.b, 1'b0, 1'b1)));
        check("tag_u", 32'(out_tag_u), 32'(e.t));
        check("tag_m", 32'(out_tag_m), 32'(e.t));
        check("valid_s", 32'(out_valid_s), 32'd1);
        check("valid_m", 32'(out_valid_m), 32'd1);
        cons_cnt++;
      end
    end
    last_acc = in_valid && in_ready_u;
    if (last_acc) scb.push_back('{din0, din1, in_tag});
    @(posedge ap_clk);
    #1;
    $display("t=%0t in_v=%0b in_r=%0b din0=%0h din1=%0h tag=%0h | out_v=%0b out_r=%0b dout=%0h otag=%0h",
             $time, in_valid, in_ready_u, din0, din1, in_tag, out_valid_u, out_ready, dout_u, out_tag_u);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int issued;
    int cons0;

    // Reset state
    #1;
    check("rst_out_valid", 32'(out_valid_u), 32'd0);
    check("rst_in_ready", 32'(in_ready_u), 32'd1);
    check("rst_dout", 32'(dout_u), 32'd0);
    check("rst_tag", 32'(out_tag_u), 32'd0);
    repeat (2) @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b1;

    // Unsigned extreme operands, single beat latency and one-cycle output pulse
    din0 = 8'd255; din1 = 10'd1023; in_tag = 4'd5; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("lat_e1", 32'(out_valid_u), 32'd0);
    step();
    check("lat_e2", 32'(out_valid_u), 32'd0);
    step();
    check("lat_e3_valid", 32'(out_valid_u), 32'd1);
    check("lat_e3_tag", 32'(out_tag_u), 32'd5);
    check("t1_dout", 32'(dout_u), 32'(EXP_T1));
    step();
    check("lat_e4_valid", 32'(out_valid_u), 32'd0);

    // Signed x signed most-negative, then unsigned x signed -1
    din0 = 8'h80; din1 = 10'h200; in_tag = 4'd6; in_valid = 1'b1;
    step();
    din0 = 8'd200; din1 = 10'h3FF; in_tag = 4'd7;
    step();
    in_valid = 1'b0;
    step();
    check("t2_dout_s", 32'(dout_s), 32'(EXP_T2));
    step();
    check("t3_dout_m", 32'(dout_m), 32'h1FF38);
    repeat (3) step();

    // Stream of 8 tagged beats with a 3-cycle consumer stall
    issued = 0;
    cons0 = cons_cnt;
    for (int c = 0; c < 40; c++) begin
      if (issued == 8 && scb.size() == 0) break;
      in_valid  = (issued < 8);
      din0      = 8'($urandom);
      din1      = 10'($urandom);
      in_tag    = 4'(issued);
      out_ready = !(c >= 4 && c <= 6);
      step();
      if (last_acc) issued++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("stream_issued", 32'(issued), 32'd8);
    check("stream_consumed", 32'(cons_cnt - cons0), 32'd8);

    // Fill the pipe behind a stalled consumer, then reset mid-cycle
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1;
      din0 = 8'($urandom); din1 = 10'($urandom); in_tag = 4'(c + 9);
      step();
    end
    in_valid = 1'b0;
    step();
    check("pre_rst_valid", 32'(out_valid_u), 32'd1);
    #1 ap_rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid_u), 32'd0);
    check("midrst_in_ready", 32'(in_ready_u), 32'd1);
    check("midrst_dout", 32'(dout_u), 32'd0);
    check("midrst_tag", 32'(out_tag_u), 32'd0);
    #1 ap_rst_n = 1'b1;
    scb.delete();
    held = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      check("post_rst_idle", 32'(out_valid_u), 32'd0);
    end

    // Randomised traffic with random backpressure
    for (int c = 0; c < 300; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      din0      = 8'($urandom);
      din1      = 10'($urandom);
      in_tag    = 4'($urandom);
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 50; c++) begin
      if (scb.size() == 0) break;
      step();
    end
    check("drain_empty", 32'(scb.size()), 32'd0);
    repeat (2) step();
    check("final_idle", 32'(out_valid_u), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
